// File: rtl/gen_chk_seq.sv
`default_nettype none
// ============================================================================
// Module   : gen_chk_seq
// Brief    : Sample checker. Collects NSAMP accepted samples of (in1,in2,in3),
//            counts samples that disagree with the expected constants, keeps
//            a per-bit sticky agreement flag for in3 and issues a pass/fail
//            verdict two cycles after the last accepted sample.
// Revision : 1.0 - initial release
// ============================================================================
module gen_chk_seq #(
  parameter int EXP1  = 4,
  parameter int EXP2  = 2,
  parameter int EXP3  = 7,
  parameter int NSAMP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [2:0] in1,
  input  logic [2:0] in2,
  input  logic [2:0] in3,
  output logic       in_ready,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [7:0] err_cnt,
  output logic [2:0] bit_ok
);

  // Expected values are compared on 3 bits only; wider parameters truncate.
  localparam logic [2:0] C_EXP1 = EXP1[2:0];
  localparam logic [2:0] C_EXP2 = EXP2[2:0];
  localparam logic [2:0] C_EXP3 = EXP3[2:0];
  // Counter value at which the accepted sample is the final one of the run.
  localparam logic [7:0] C_LAST = 8'(NSAMP - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_JUDGE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] err_q, err_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;

  logic       w_accept;
  logic       w_mismatch;
  logic       w_run_start;

  assign w_accept    = (state_q == S_COLLECT) && in_valid;
  assign w_mismatch  = (in1 != C_EXP1) || (in2 != C_EXP2) || (in3 != C_EXP3);
  // A run can only be (re)started from IDLE or DONE; start elsewhere is ignored.
  assign w_run_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state and datapath update for the run sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          cnt_d   = 8'd0;
          err_d   = 8'd0;
        end
      end
      S_COLLECT: begin
        if (w_accept) begin
          cnt_d = cnt_q + 8'd1;
          // Saturate so a long run of bad samples never wraps to look clean.
          if (w_mismatch && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
          if (cnt_q == C_LAST) begin
            state_d = S_JUDGE;
          end
        end
      end
      S_JUDGE: begin
        // Verdict is registered here so it appears on entry to DONE.
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = (err_q == 8'd0);
        fail_d  = (err_q != 8'd0);
      end
      S_DONE: begin
        if (start) begin
          state_d = S_COLLECT;
          cnt_d   = 8'd0;
          err_d   = 8'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 8'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // One sticky agreement flag per in3 bit.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic lane_ok_q;

    // Lane clears on any accepted sample whose bit disagrees; re-armed per run.
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_ok_q <= 1'b1;
      end else if (w_run_start) begin
        lane_ok_q <= 1'b1;
      end else if (w_accept && (in3[gi] != C_EXP3[gi])) begin
        lane_ok_q <= 1'b0;
      end
    end

    assign bit_ok[gi] = lane_ok_q;
  end

  assign in_ready = (state_q == S_COLLECT);
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign err_cnt  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_chk_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_chk_seq
// Brief    : Directed self-checking bench for gen_chk_seq (NSAMP=4 instance
//            plus an NSAMP=255 instance for the saturation/restart case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_chk_seq;

  logic       clk;
  logic       rst, start, in_valid;
  logic [2:0] in1, in2, in3;
  logic       in_ready, done, pass, fail;
  logic [7:0] err_cnt;
  logic [2:0] bit_ok;

  logic       rst2, start2, in_valid2;
  logic [2:0] in1_2, in2_2, in3_2;
  logic       in_ready2, done2, pass2, fail2;
  logic [7:0] err_cnt2;
  logic [2:0] bit_ok2;

  int n_checks = 0;
  int n_errors = 0;

  gen_chk_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in_ready (in_ready),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .err_cnt  (err_cnt),
    .bit_ok   (bit_ok)
  );

  gen_chk_seq #(.NSAMP(255)) dut255 (
    .clk      (clk),
    .rst      (rst2),
    .start    (start2),
    .in_valid (in_valid2),
    .in1      (in1_2),
    .in2      (in2_2),
    .in3      (in3_2),
    .in_ready (in_ready2),
    .done     (done2),
    .pass     (pass2),
    .fail     (fail2),
    .err_cnt  (err_cnt2),
    .bit_ok   (bit_ok2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are seen by the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    in_valid = 1'b1;
    in1 = a; in2 = b; in3 = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run255();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("n255_restart_err", err_cnt2, 0);
    in_valid2 = 1'b1;
    in1_2 = 3'd0; in2_2 = 3'd0; in3_2 = 3'd0;
    for (int k = 0; k < 255; k++) tick();
    in_valid2 = 1'b0;
    check("n255_judge_notdone", done2, 0);
    tick();
    check("n255_done", done2, 1);
    check("n255_fail", fail2, 1);
    check("n255_pass", pass2, 0);
    check("n255_err", err_cnt2, 255);
    check("n255_bitok", bit_ok2, 3'b000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; in3 = '0;
    rst2 = 1'b1; start2 = 1'b0; in_valid2 = 1'b0; in1_2 = '0; in2_2 = '0; in3_2 = '0;
    tick();
    tick();
    rst = 1'b0; rst2 = 1'b0;

    // Reset state
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_err", err_cnt, 0);
    check("rst_bitok", bit_ok, 3'b111);

    // All-good run, back to back
    pulse_start();
    check("t1_ready", in_ready, 1);
    send(3'd4, 3'd2, 3'd7);
    send(3'd4, 3'd2, 3'd7);
    send(3'd4, 3'd2, 3'd7);
    send(3'd4, 3'd2, 3'd7);
    check("t1_judge_done", done, 0);
    check("t1_judge_ready", in_ready, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_fail", fail, 0);
    check("t1_err", err_cnt, 0);
    check("t1_bitok", bit_ok, 3'b111);
    tick();
    check("t1_hold_done", done, 1);

    // Mixed run, started from DONE
    pulse_start();
    check("t2_start_done", done, 0);
    check("t2_start_pass", pass, 0);
    send(3'd4, 3'd2, 3'd7);
    send(3'd4, 3'd2, 3'd5);
    send(3'd4, 3'd3, 3'd7);
    send(3'd4, 3'd2, 3'd7);
    tick();
    check("t2_done", done, 1);
    check("t2_fail", fail, 1);
    check("t2_pass", pass, 0);
    check("t2_err", err_cnt, 2);
    check("t2_bitok", bit_ok, 3'b101);

    // Run with in_valid gaps of 3 idle cycles
    pulse_start();
    check("t3_restart_err", err_cnt, 0);
    check("t3_restart_bitok", bit_ok, 3'b111);
    for (int s = 0; s < 4; s++) begin
      send(3'd4, 3'd2, 3'd7);
      if (s < 3) begin
        tick(); tick(); tick();
        check("t3_gap_ready", in_ready, 1);
        check("t3_gap_done", done, 0);
      end
    end
    check("t3_judge_done", done, 0);
    tick();
    check("t3_done", done, 1);
    check("t3_pass", pass, 1);

    // Reset mid-run discards partial results
    pulse_start();
    send(3'd1, 3'd2, 3'd6);
    send(3'd1, 3'd2, 3'd6);
    check("t4_partial_err", err_cnt, 2);
    rst = 1'b1;
    in_valid = 1'b1; in1 = 3'd1; start = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    check("t4_rst_ready", in_ready, 0);
    check("t4_rst_err", err_cnt, 0);
    check("t4_rst_bitok", bit_ok, 3'b111);
    check("t4_rst_done", done, 0);
    tick();
    check("t4_idle_stable_err", err_cnt, 0);
    pulse_start();
    send(3'd4, 3'd2, 3'd7);
    send(3'd4, 3'd2, 3'd7);
    send(3'd4, 3'd2, 3'd7);
    check("t4_cnt_cleared_ready", in_ready, 1);
    send(3'd4, 3'd2, 3'd7);
    tick();
    check("t4_done", done, 1);
    check("t4_pass", pass, 1);

    // Start pulses during COLLECT and JUDGE are ignored
    pulse_start();
    send(3'd4, 3'd2, 3'd3);
    send(3'd4, 3'd2, 3'd7);
    pulse_start();
    check("t5_collect_start_err", err_cnt, 1);
    check("t5_collect_start_ready", in_ready, 1);
    send(3'd4, 3'd2, 3'd7);
    send(3'd4, 3'd2, 3'd7);
    check("t5_judge_ready", in_ready, 0);
    pulse_start();
    check("t5_done", done, 1);
    check("t5_fail", fail, 1);
    check("t5_err", err_cnt, 1);
    check("t5_bitok", bit_ok, 3'b011);
    tick();
    check("t5_hold_done", done, 1);
    check("t5_hold_ready", in_ready, 0);

    // NSAMP=255, every sample bad, two runs back to back
    run255();
    run255();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gen_chk_seq.md
GEN_CHK_SEQ -- requirements
Module: gen_chk_seq

Interface
REQ-001 SHALL have parameter EXP1, default 4 (2**2), expected value of in1.
REQ-002 SHALL have parameter EXP2, default 2 (2**1), expected value of in2.
REQ-003 SHALL have parameter EXP3, default 7, expected value of in3.
REQ-004 SHALL have parameter NSAMP, default 4, range 1..255, samples per check run.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a check run.
REQ-008 SHALL have port in_valid  input  1  sample present on in1/in2/in3.
REQ-009 SHALL have port in1  input  3  sample of the first checked value.
REQ-010 SHALL have port in2  input  3  sample of the second checked value.
REQ-011 SHALL have port in3  input  3  sample of the bitwise-generated value.
REQ-012 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-013 SHALL have port done  output  1  run complete; verdict valid.
REQ-014 SHALL have port pass  output  1  run complete with zero mismatches.
REQ-015 SHALL have port fail  output  1  run complete with one or more mismatches.
REQ-016 SHALL have port err_cnt  output  8  mismatching samples in current/last run.
REQ-017 SHALL have port bit_ok  output  3  per-bit sticky agreement of in3 with EXP3.

Function
REQ-018 SHALL implement states IDLE, COLLECT, JUDGE, DONE.
REQ-019 IDLE: start=1 -> COLLECT next cycle; err_cnt cleared to 0, bit_ok set to 3'b111, sample counter cleared.
REQ-020 in_ready SHALL be 1 exactly when state is COLLECT; a sample is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-021 accepted sample SHALL be a mismatch if in1!=EXP1 or in2!=EXP2 or in3!=EXP3 (3-bit compares; EXP values truncated to 3 bits).
REQ-022 each mismatch SHALL increment err_cnt by 1, saturating at 255.
REQ-023 bit_ok SHALL be built as three generate-loop lanes; lane i clears (sticky) when an accepted sample has in3[i]!=EXP3[i].
REQ-024 after the NSAMP-th accepted sample, state SHALL go COLLECT -> JUDGE on the next edge; in_valid=0 cycles stall without counting.
REQ-025 JUDGE SHALL last exactly one cycle, then DONE; pass/fail/done registered on entry to DONE.
REQ-026 DONE: done=1, pass=(err_cnt==0), fail=!pass; outputs held until start.
REQ-027 start in DONE SHALL begin a new run (same action as REQ-019), deasserting done/pass/fail next cycle.
REQ-028 start in COLLECT or JUDGE SHALL be ignored.
REQ-029 latency: last accepted sample to done=1 SHALL be exactly 2 cycles.
REQ-030 pass and fail SHALL never both be 1; both 0 whenever done=0.
REQ-031 err_cnt and bit_ok SHALL remain readable and stable in DONE and IDLE.

Reset
REQ-032 rst=1 SHALL on the next edge force IDLE, in_ready=0, done=0, pass=0, fail=0, err_cnt=0, bit_ok=3'b111, sample counter 0.
REQ-033 rst SHALL take priority over start and in_valid, including mid-run in COLLECT (partial run discarded).

Verification
REQ-034 reset, start, 4 samples (4,2,7) back-to-back -> done=1 two cycles after 4th, pass=1, fail=0, err_cnt=0, bit_ok=111.
REQ-035 start, samples (4,2,7),(4,2,5),(4,3,7),(4,2,7) -> fail=1, err_cnt=2, bit_ok=101.
REQ-036 start, samples with in_valid gaps of 3 idle cycles -> only valid cycles counted, done after 4th valid sample.
REQ-037 NSAMP=255, all samples mismatching, two back-to-back runs -> err_cnt=255 each run, no wrap; second run restarts from 0.
REQ-038 rst asserted after 2 samples in COLLECT -> next cycle all outputs at reset values; new start runs full 4 samples.
REQ-039 start pulsed during COLLECT and JUDGE -> ignored, sample count unchanged, single done pulse sequence.
